// File: rtl/isqrt_input_ctrl.sv
// rtl/isqrt_input_ctrl.sv - button/switch front-end for isqrt: sync, debounce, capture, one-shot start, hold-off
// Optional switch-stability auto-start is built when ISQRT_IN_AUTOSTART_EN is defined.
module isqrt_input_ctrl #(
    parameter int DB_CYCLES   = 16,
    parameter int HOLD_CYCLES = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn,
    input  logic [7:0] sw,
    output logic [7:0] a,
    output logic       start,
    output logic       busy
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_HOLD,
        S_WAIT_REL
    } state_t;

    logic           r_btn_m;
    logic           r_btn_s;
    logic [7:0]     r_sw_m;
    logic [7:0]     r_sw_s;
    logic           r_btn_db;
    logic           r_btn_db_q;
    logic           r_press;
    logic [DBW-1:0] r_db_cnt;
    logic [HW-1:0]  r_hold_cnt;
    state_t         r_state;
    logic           w_auto;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_btn_m <= 1'b0;
            r_btn_s <= 1'b0;
            r_sw_m  <= 8'h00;
            r_sw_s  <= 8'h00;
        end else begin
            r_btn_m <= btn;
            r_btn_s <= r_btn_m;
            r_sw_m  <= sw;
            r_sw_s  <= r_sw_m;
        end
    end

    // Press is registered so the FSM sees a clean single-cycle pulse one edge after acceptance.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_btn_db   <= 1'b0;
            r_btn_db_q <= 1'b0;
            r_press    <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_btn_db_q <= r_btn_db;
            r_press    <= r_btn_db & ~r_btn_db_q;
            if (r_btn_s == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_btn_db <= r_btn_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

`ifdef ISQRT_IN_AUTOSTART_EN
    logic [7:0]     r_sw_prev;
    logic [DBW-1:0] r_sw_cnt;

    assign w_auto = (r_state == S_IDLE) && (r_sw_s == r_sw_prev) &&
                    (r_sw_s != a) && (r_sw_cnt == DB_LAST);

    // Counts consecutive idle cycles with a new, unchanging switch value.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_sw_prev <= 8'h00;
            r_sw_cnt  <= '0;
        end else begin
            r_sw_prev <= r_sw_s;
            if ((r_state != S_IDLE) || w_auto || (r_sw_s != r_sw_prev) || (r_sw_s == a)) begin
                r_sw_cnt <= '0;
            end else begin
                r_sw_cnt <= r_sw_cnt + 1'b1;
            end
        end
    end
`else
    assign w_auto = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            a          <= 8'h00;
            start      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_press || w_auto) begin
                        a       <= r_sw_s;
                        start   <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    r_hold_cnt <= HOLD_LAST;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        if (r_btn_db) begin
                            r_state <= S_WAIT_REL;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                S_WAIT_REL: begin
                    if (!r_btn_db) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_input_ctrl.sv
// tb/tb_isqrt_input_ctrl.sv - vector table, random model comparison and auto-start check for isqrt_input_ctrl
module tb_isqrt_input_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 6;

    logic       clk = 1'b0;
    logic       clr;
    logic       btn;
    logic [7:0] sw;
    logic [7:0] a;
    logic       start;
    logic       busy;

    int n_total = 0;
    int n_pass  = 0;

    isqrt_input_ctrl #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn),
        .sw    (sw),
        .a     (a),
        .start (start),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference model: sync pipes, last-DB-samples debounce, and busy derived from age since start.
    logic       m_bm = 0, m_bs = 0, m_db = 0, m_db_q = 0, m_press = 0;
    logic [7:0] m_swm = 0, m_sws = 0, m_a = 0;
    logic       m_start = 0, m_busy = 0;
    int         m_age = 0;
    logic       hist[$];

    task automatic model_step(input logic c, input logic b, input logic [7:0] s);
        logic n_press;
        bit   all_diff;
        if (c) begin
            m_bm = 0; m_bs = 0; m_db = 0; m_db_q = 0; m_press = 0;
            m_swm = 0; m_sws = 0; m_a = 0; m_start = 0; m_busy = 0; m_age = 0;
            hist.delete();
        end else begin
            m_start = 0;
            if (!m_busy) begin
                if (m_press) begin
                    m_a = m_sws; m_start = 1; m_busy = 1; m_age = 0;
                end
            end else begin
                m_age++;
                if (m_age > HOLD) m_busy = m_db;
            end
            n_press = m_db & ~m_db_q;
            m_db_q  = m_db;
            hist.push_back(m_bs);
            if (hist.size() > DB) void'(hist.pop_front());
            all_diff = (hist.size() == DB);
            foreach (hist[i]) if (hist[i] == m_db) all_diff = 0;
            if (all_diff) m_db = m_bs;
            m_press = n_press;
            m_bs = m_bm; m_bm = b;
            m_sws = m_swm; m_swm = s;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input logic c, input logic b, input logic [7:0] s, input bit use_model);
        clr = c; btn = b; sw = s;
        @(posedge clk);
        model_step(c, b, s);
        @(negedge clk);
        if (use_model) begin
            chk("model_a", a, m_a);
            chk("model_start", {7'd0, start}, {7'd0, m_start});
            chk("model_busy", {7'd0, busy}, {7'd0, m_busy});
        end
    endtask

    typedef struct {
        logic       c;
        logic       b;
        logic [7:0] s;
        int         n;
        logic [7:0] ea;
        logic       es;
        logic       eb;
    } vec_t;

    localparam int NV = 29;
    vec_t       vec[NV];
    int         hold_left;
    logic       rb, rc;
    logic [7:0] rs;
    int         nstart;

    initial begin
        clr = 1'b1; btn = 1'b0; sw = 8'h00;
        @(negedge clk);

        vec[0]  = '{1'b1, 1'b1, 8'hFF, 3,  8'h00, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 1'b0, 8'h51, 4,  8'h00, 1'b0, 1'b0};
        vec[2]  = '{1'b0, 1'b1, 8'h51, 7,  8'h00, 1'b0, 1'b0};
        vec[3]  = '{1'b0, 1'b1, 8'h51, 1,  8'h51, 1'b1, 1'b1};
        vec[4]  = '{1'b0, 1'b1, 8'h51, 1,  8'h51, 1'b0, 1'b1};
        vec[5]  = '{1'b0, 1'b1, 8'h51, 21, 8'h51, 1'b0, 1'b1};
        vec[6]  = '{1'b0, 1'b0, 8'h51, 6,  8'h51, 1'b0, 1'b1};
        vec[7]  = '{1'b0, 1'b0, 8'h51, 1,  8'h51, 1'b0, 1'b0};
        vec[8]  = '{1'b0, 1'b1, 8'hA9, 2,  8'h51, 1'b0, 1'b0};
        vec[9]  = '{1'b0, 1'b0, 8'hA9, 2,  8'h51, 1'b0, 1'b0};
        vec[10] = '{1'b0, 1'b1, 8'hA9, 2,  8'h51, 1'b0, 1'b0};
        vec[11] = '{1'b0, 1'b0, 8'hA9, 2,  8'h51, 1'b0, 1'b0};
        vec[12] = '{1'b0, 1'b1, 8'hA9, 2,  8'h51, 1'b0, 1'b0};
        vec[13] = '{1'b0, 1'b0, 8'hA9, 2,  8'h51, 1'b0, 1'b0};
        vec[14] = '{1'b0, 1'b1, 8'hA9, 7,  8'h51, 1'b0, 1'b0};
        vec[15] = '{1'b0, 1'b1, 8'hA9, 1,  8'hA9, 1'b1, 1'b1};
        vec[16] = '{1'b0, 1'b0, 8'hA9, 2,  8'hA9, 1'b0, 1'b1};
        vec[17] = '{1'b0, 1'b1, 8'h10, 2,  8'hA9, 1'b0, 1'b1};
        vec[18] = '{1'b0, 1'b1, 8'h10, 10, 8'hA9, 1'b0, 1'b1};
        vec[19] = '{1'b0, 1'b0, 8'h10, 6,  8'hA9, 1'b0, 1'b1};
        vec[20] = '{1'b0, 1'b0, 8'h10, 1,  8'hA9, 1'b0, 1'b0};
        vec[21] = '{1'b0, 1'b1, 8'h10, 7,  8'hA9, 1'b0, 1'b0};
        vec[22] = '{1'b0, 1'b1, 8'h10, 1,  8'h10, 1'b1, 1'b1};
        vec[23] = '{1'b0, 1'b1, 8'h10, 3,  8'h10, 1'b0, 1'b1};
        vec[24] = '{1'b1, 1'b1, 8'h10, 1,  8'h00, 1'b0, 1'b0};
        vec[25] = '{1'b0, 1'b1, 8'h10, 7,  8'h00, 1'b0, 1'b0};
        vec[26] = '{1'b0, 1'b1, 8'h10, 1,  8'h10, 1'b1, 1'b1};
        vec[27] = '{1'b0, 1'b1, 8'h10, 20, 8'h10, 1'b0, 1'b1};
        vec[28] = '{1'b0, 1'b0, 8'h10, 7,  8'h10, 1'b0, 1'b0};

`ifndef ISQRT_IN_AUTOSTART_EN
        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < vec[i].n; k++) tick(vec[i].c, vec[i].b, vec[i].s, 1'b1);
            chk($sformatf("vec%0d_a", i), a, vec[i].ea);
            chk($sformatf("vec%0d_start", i), {7'd0, start}, {7'd0, vec[i].es});
            chk($sformatf("vec%0d_busy", i), {7'd0, busy}, {7'd0, vec[i].eb});
        end

        hold_left = 0; rb = 1'b0; rs = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            if (hold_left == 0) begin
                rb = 1'($urandom_range(0, 1));
                hold_left = $urandom_range(1, 14);
                if ($urandom_range(0, 3) == 0) rs = 8'($urandom);
            end
            hold_left--;
            rc = ($urandom_range(0, 149) == 0);
            tick(rc, rb, rs, 1'b1);
        end

        tick(1'b1, 1'b0, 8'h00, 1'b1);
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        nstart = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b0, 8'h40, 1'b1);
            if (start) nstart++;
        end
        chk("noauto_starts", 8'(nstart), 8'd0);
        chk("noauto_a", a, 8'h00);
`else
        for (int k = 0; k < vec[0].n; k++) tick(vec[0].c, vec[0].b, vec[0].s, 1'b1);
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        for (int k = 1; k <= DB + 5; k++) begin
            tick(1'b0, 1'b0, 8'h40, 1'b0);
            chk($sformatf("auto_start_edge%0d", k), {7'd0, start}, {7'd0, (k == DB + 3)});
        end
        chk("auto_a", a, 8'h40);
        chk("auto_busy", {7'd0, busy}, 8'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
